// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data shared-memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        ERR   = 2'd3
    } arb_state_t;

    localparam int DEF_MAX_D_RUN = 4;
    localparam int DEF_TIMEOUT   = 16;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory port,
// favouring data with a bounded run length and flagging stuck memory.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_D_RUN = DEF_MAX_D_RUN,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        err
);

    localparam int RUN_W  = $clog2(MAX_D_RUN + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(MAX_D_RUN);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    arb_state_t        state, state_nx;
    logic [RUN_W-1:0]  d_run, d_run_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
    logic              mem_req_nx, mem_we_nx, i_ready_nx, d_ready_nx, err_nx;
    logic [31:0]       mem_addr_nx, mem_wdata_nx, i_rdata_nx, d_rdata_nx;

    assign stall = (i_req & ~i_ready) | (d_req & ~d_ready);

    always_comb begin
        state_nx     = state;
        d_run_nx     = d_run;
        wait_cnt_nx  = wait_cnt;
        mem_req_nx   = mem_req;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        i_rdata_nx   = i_rdata;
        d_rdata_nx   = d_rdata;
        i_ready_nx   = 1'b0;
        d_ready_nx   = 1'b0;
        err_nx       = err;
        case (state)
            IDLE: begin
                // No grant while a ready pulse is out: the requester has not
                // yet had a chance to drop or replace its request.
                if (!i_ready && !d_ready) begin
                    if (d_req && (!i_req || d_run < RUN_MAX)) begin
                        state_nx     = GNT_D;
                        wait_cnt_nx  = '0;
                        mem_req_nx   = 1'b1;
                        mem_we_nx    = d_we;
                        mem_addr_nx  = d_addr;
                        mem_wdata_nx = d_we ? d_wdata : 32'd0;
                        if (i_req) d_run_nx = d_run + RUN_W'(1);
                    end else if (i_req) begin
                        state_nx     = GNT_I;
                        wait_cnt_nx  = '0;
                        d_run_nx     = '0;
                        mem_req_nx   = 1'b1;
                        mem_we_nx    = 1'b0;
                        mem_addr_nx  = i_addr;
                        mem_wdata_nx = 32'd0;
                    end
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ack) begin
                    state_nx     = IDLE;
                    mem_req_nx   = 1'b0;
                    mem_we_nx    = 1'b0;
                    mem_addr_nx  = 32'd0;
                    mem_wdata_nx = 32'd0;
                    if (state == GNT_I) begin
                        i_rdata_nx = mem_rdata;
                        i_ready_nx = 1'b1;
                    end else begin
                        d_rdata_nx = mem_rdata;
                        d_ready_nx = 1'b1;
                    end
                end else begin
                    wait_cnt_nx = wait_cnt + WAIT_W'(1);
                    if (wait_cnt_nx == WAIT_MAX) begin
                        state_nx     = ERR;
                        err_nx       = 1'b1;
                        mem_req_nx   = 1'b0;
                        mem_we_nx    = 1'b0;
                        mem_addr_nx  = 32'd0;
                        mem_wdata_nx = 32'd0;
                    end
                end
            end
            default: begin
                state_nx = ERR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            d_run     <= '0;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            i_rdata   <= 32'd0;
            d_rdata   <= 32'd0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            d_run     <= d_run_nx;
            wait_cnt  <= wait_cnt_nx;
            mem_req   <= mem_req_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            i_rdata   <= i_rdata_nx;
            d_rdata   <= d_rdata_nx;
            i_ready   <= i_ready_nx;
            d_ready   <= d_ready_nx;
            err       <= err_nx;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner cases
// and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int MAXR = 4;
    localparam int TMO  = 16;

    logic        clk, rst;
    logic        i_req, i_ready, d_req, d_we, d_ready;
    logic        mem_req, mem_we, mem_ack, stall, err;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_bad = 0;

    mem_arbiter #(.MAX_D_RUN(MAXR), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before the test completed");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        ir, dr, we, ack;
        logic [31:0] rd;
        logic        e_mreq, e_mwe, e_iry, e_dry, e_stall;
        logic [31:0] e_addr, e_wd, e_ird, e_drd;
    } vec_t;

    vec_t tbl [10];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        step();
        step();
        rst = 1'b1;
    endtask

    // reference-model state for the randomized run
    logic        m_busy, p_ack, p_ir, p_dr, p_iry, p_dry, exp_ir, exp_dr;
    logic        e_we;
    logic [31:0] m_ird, m_drd, p_rd, e_addr, e_wd;
    int          m_port, m_run, m_lat, ngr, cnt, gnt [6];
    int          exp_g [6];
    logic [31:0] mem_arr [16];

    initial begin
        rst = 1'b0; i_req = 1'b1; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;

        // reset values, with a request held so stall shows through reset
        step();
        step();
        chk1("reset mem_req", mem_req, 1'b0);
        chk1("reset mem_we", mem_we, 1'b0);
        chk32("reset mem_addr", mem_addr, 32'd0);
        chk32("reset mem_wdata", mem_wdata, 32'd0);
        chk1("reset i_ready", i_ready, 1'b0);
        chk1("reset d_ready", d_ready, 1'b0);
        chk32("reset i_rdata", i_rdata, 32'd0);
        chk32("reset d_rdata", d_rdata, 32'd0);
        chk1("reset err", err, 1'b0);
        chk1("reset stall", stall, 1'b1);
        i_req = 1'b0;
        rst = 1'b1;

        // fetch, store with 3-cycle memory, spurious ack while idle
        i_addr = 32'h0040_0000; d_addr = 32'h1001_0004; d_wdata = 32'hDEAD_BEEF;
        tbl[0] = '{1,0,0,0,32'h0,          1,0,0,0,1, 32'h0040_0000, 32'h0, 32'h0,          32'h0};
        tbl[1] = '{1,0,0,1,32'h2008_0005,  0,0,1,0,0, 32'h0,         32'h0, 32'h2008_0005, 32'h0};
        tbl[2] = '{0,0,0,0,32'h0,          0,0,0,0,0, 32'h0,         32'h0, 32'h2008_0005, 32'h0};
        tbl[3] = '{0,1,1,0,32'h0,          1,1,0,0,1, 32'h1001_0004, 32'hDEAD_BEEF, 32'h2008_0005, 32'h0};
        tbl[4] = '{0,1,1,0,32'h0,          1,1,0,0,1, 32'h1001_0004, 32'hDEAD_BEEF, 32'h2008_0005, 32'h0};
        tbl[5] = '{0,1,1,0,32'h0,          1,1,0,0,1, 32'h1001_0004, 32'hDEAD_BEEF, 32'h2008_0005, 32'h0};
        tbl[6] = '{0,1,1,1,32'h1234_5678,  0,0,0,1,0, 32'h0,         32'h0, 32'h2008_0005, 32'h1234_5678};
        tbl[7] = '{0,0,0,0,32'h0,          0,0,0,0,0, 32'h0,         32'h0, 32'h2008_0005, 32'h1234_5678};
        tbl[8] = '{0,0,0,1,32'hFFFF_FFFF,  0,0,0,0,0, 32'h0,         32'h0, 32'h2008_0005, 32'h1234_5678};
        tbl[9] = '{0,0,0,0,32'h0,          0,0,0,0,0, 32'h0,         32'h0, 32'h2008_0005, 32'h1234_5678};
        for (int k = 0; k < 10; k++) begin
            i_req = tbl[k].ir; d_req = tbl[k].dr; d_we = tbl[k].we;
            mem_ack = tbl[k].ack; mem_rdata = tbl[k].rd;
            step();
            chk1($sformatf("row%0d mem_req", k), mem_req, tbl[k].e_mreq);
            chk1($sformatf("row%0d mem_we", k), mem_we, tbl[k].e_mwe);
            chk1($sformatf("row%0d i_ready", k), i_ready, tbl[k].e_iry);
            chk1($sformatf("row%0d d_ready", k), d_ready, tbl[k].e_dry);
            chk1($sformatf("row%0d stall", k), stall, tbl[k].e_stall);
            chk32($sformatf("row%0d mem_wdata", k), mem_wdata, tbl[k].e_wd);
            chk32($sformatf("row%0d i_rdata", k), i_rdata, tbl[k].e_ird);
            chk32($sformatf("row%0d d_rdata", k), d_rdata, tbl[k].e_drd);
            if (tbl[k].e_mreq) chk32($sformatf("row%0d mem_addr", k), mem_addr, tbl[k].e_addr);
        end
        mem_ack = 1'b0;

        // contention with instant acks: expect D,D,D,D,I,D
        do_reset();
        i_addr = 32'h0040_0000; d_addr = 32'h1001_0004; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        exp_g = '{1, 1, 1, 1, 0, 1};
        for (int k = 0; k < 6; k++) gnt[k] = -1;
        ngr = 0;
        for (int c = 0; c < 60 && ngr < 6; c++) begin
            step();
            if (mem_req && !mem_ack) begin
                gnt[ngr] = (mem_addr == d_addr) ? 1 : 0;
                ngr++;
                mem_ack = 1'b1;
            end else begin
                mem_ack = 1'b0;
            end
        end
        mem_ack = 1'b0; i_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 6; k++) chk32($sformatf("contention grant%0d (1=D)", k), gnt[k], exp_g[k]);

        // timeout: no ack ever arrives
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0008;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (err) break;
            if (mem_req) cnt++;
        end
        chk32("timeout mem_req cycles", cnt, TMO);
        chk1("timeout err", err, 1'b1);
        chk1("timeout mem_req dropped", mem_req, 1'b0);
        for (int c = 0; c < 6; c++) begin
            mem_ack = (c == 2);
            step();
            chk1($sformatf("err hold d_ready c%0d", c), d_ready, 1'b0);
            chk1($sformatf("err hold stall c%0d", c), stall, 1'b1);
            chk1($sformatf("err hold err c%0d", c), err, 1'b1);
            chk1($sformatf("err hold mem_req c%0d", c), mem_req, 1'b0);
        end
        mem_ack = 1'b0;

        // reset in the middle of a data grant
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0010; d_wdata = 32'h0BAD_F00D;
        step();
        step();
        chk1("midrst mem_req before", mem_req, 1'b1);
        rst = 1'b0;
        #1;
        chk1("midrst mem_req", mem_req, 1'b0);
        chk1("midrst mem_we", mem_we, 1'b0);
        chk32("midrst mem_addr", mem_addr, 32'd0);
        chk32("midrst mem_wdata", mem_wdata, 32'd0);
        chk1("midrst err", err, 1'b0);
        chk1("midrst stall", stall, 1'b1);
        step();
        rst = 1'b1;
        step();
        chk1("midrst regrant mem_req", mem_req, 1'b1);
        chk1("midrst no d_ready", d_ready, 1'b0);
        chk32("midrst regrant addr", mem_addr, 32'h1001_0010);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ack = 1'b0; d_req = 1'b0;
        chk1("midrst d_ready", d_ready, 1'b1);
        chk32("midrst d_rdata", d_rdata, 32'hCAFE_F00D);
        step();
        chk1("midrst d_ready single", d_ready, 1'b0);

        // randomized traffic against the transaction-level model
        do_reset();
        for (int k = 0; k < 16; k++) mem_arr[k] = $urandom();
        m_busy = 1'b0; p_ack = 1'b0; p_ir = 1'b0; p_dr = 1'b0; p_iry = 1'b0; p_dry = 1'b0;
        m_ird = 32'd0; m_drd = 32'd0; p_rd = 32'd0; m_port = 0; m_run = 0; m_lat = 0;
        for (int c = 0; c < 1500; c++) begin
            step();
            exp_ir = 1'b0; exp_dr = 1'b0;
            if (m_busy && p_ack) begin
                m_busy = 1'b0;
                if (m_port == 0) begin exp_ir = 1'b1; m_ird = p_rd; end
                else begin exp_dr = 1'b1; m_drd = p_rd; end
            end else if (!m_busy && !p_iry && !p_dry && (p_ir || p_dr)) begin
                if (p_dr && (!p_ir || m_run < MAXR)) begin
                    m_port = 1;
                    if (p_ir && m_run < MAXR) m_run++;
                end else begin
                    m_port = 0;
                    m_run = 0;
                end
                m_busy = 1'b1;
                m_lat = $urandom_range(0, 4);
            end
            e_addr = (m_port == 1) ? d_addr : i_addr;
            e_we   = m_busy && (m_port == 1) && d_we;
            e_wd   = e_we ? d_wdata : 32'd0;
            chk1("rnd i_ready", i_ready, exp_ir);
            chk1("rnd d_ready", d_ready, exp_dr);
            chk32("rnd i_rdata", i_rdata, m_ird);
            chk32("rnd d_rdata", d_rdata, m_drd);
            chk1("rnd mem_req", mem_req, m_busy);
            chk1("rnd mem_we", mem_we, e_we);
            chk32("rnd mem_wdata", mem_wdata, e_wd);
            if (m_busy) chk32("rnd mem_addr", mem_addr, e_addr);
            chk1("rnd stall", stall, (i_req & ~exp_ir) | (d_req & ~exp_dr));
            chk1("rnd err", err, 1'b0);

            p_ack = 1'b0;
            if (m_busy) begin
                if (m_lat == 0) begin
                    p_ack = 1'b1;
                    if (m_port == 1 && d_we) begin
                        mem_arr[e_addr[5:2]] = d_wdata;
                        p_rd = $urandom();
                    end else begin
                        p_rd = mem_arr[e_addr[5:2]];
                    end
                end else begin
                    m_lat--;
                end
            end
            mem_ack = p_ack;
            mem_rdata = p_ack ? p_rd : $urandom();

            if (exp_ir || !i_req) begin
                i_req = 1'b0;
                if ($urandom_range(0, 99) < 40) begin
                    i_req = 1'b1;
                    i_addr = 32'h0040_0000 | {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                end
            end
            if (exp_dr || !d_req) begin
                d_req = 1'b0;
                if ($urandom_range(0, 99) < 40) begin
                    d_req = 1'b1;
                    d_we = 1'($urandom_range(0, 1));
                    d_addr = 32'h1001_0000 | {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                    d_wdata = $urandom();
                end
            end
            p_ir = i_req; p_dr = d_req; p_iry = exp_ir; p_dry = exp_dr;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
